// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the bit-serial adder sequencer: FSM state
//   encodings and the default operand width.
package serial_pkg;

    localparam int SA_WIDTH_DEF = 8;

    // 2'b11 is unused; the FSM steers it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sa_state_e;

endpackage

// File: rtl/serial_add_slice.sv
// serial_add_slice
//   One-bit full adder with a registered carry.
//   clk      : rising-edge clock
//   clr      : synchronous active-low clear of the carry flop
//   en       : advance the carry with the full-adder carry-out
//   a, b     : operand bits for this cycle
//   cin_load : value loaded into the carry when load is high
//   load     : seed the carry (takes priority over en)
//   s        : combinational sum bit (a ^ b ^ carry)
//   c        : current carry flop value
module serial_add_slice (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic cin_load,
    input  logic load,
    output logic s,
    output logic c
);

    logic r_carry;
    logic w_cnext;

    assign s       = a ^ b ^ r_carry;
    assign w_cnext = (a & b) | (a & r_carry) | (b & r_carry);
    assign c       = r_carry;

    always_ff @(posedge clk) begin
        if (!clr)      r_carry <= 1'b0;
        else if (load) r_carry <= cin_load;
        else if (en)   r_carry <= w_cnext;
    end

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq
//   Sequences a WIDTH-bit addition through a one-bit serial adder slice,
//   LSB first, then presents {cout, sum} on a valid/ready handshake.
//   clk                 : rising-edge clock
//   clr                 : synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout)
//   busy                : high while shifting or holding a result
module serial_add_seq
    import serial_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        r_state;
    sa_state_e        w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;

    logic w_accept;
    logic w_shift;
    logic w_s;
    logic w_carry;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_shift  = (r_state == ST_SHIFT);

    serial_add_slice u_slice (
        .clk      (clk),
        .clr      (clr),
        .en       (w_shift),
        .a        (r_a_sr[0]),
        .b        (r_b_sr[0]),
        .cin_load (in_cin),
        .load     (w_accept),
        .s        (w_s),
        .c        (w_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!clr) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)           w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_LAST)  w_next = ST_DONE;
            ST_DONE:  if (out_ready)          w_next = ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    // Datapath: operand/sum shift registers and bit counter
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr   <= in_a;
            r_b_sr   <= in_b;
            r_sum_sr <= '0;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            r_sum_sr <= (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
            // Hold at the last count rather than wrapping.
            if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Outputs come from registered state; clr low masks everything to idle values.
    assign in_ready  = clr && (r_state == ST_IDLE);
    assign out_valid = clr && (r_state == ST_DONE);
    assign busy      = clr && ((r_state == ST_SHIFT) || (r_state == ST_DONE));
    assign out_sum   = out_valid ? r_sum_sr : '0;
    assign out_cout  = out_valid ? w_carry  : 1'b0;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    logic       clk = 1'b0;
    logic       clr;
    // WIDTH=8 instance
    logic       iv, ir, cin, ov, ordy, cout, bsy;
    logic [7:0] a, b, sum;
    // WIDTH=1 instance
    logic       iv1, ir1, a1, b1, cin1, ov1, ordy1, sum1, cout1, bsy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .in_valid(iv), .in_ready(ir),
        .in_a(a), .in_b(b), .in_cin(cin),
        .out_valid(ov), .out_ready(ordy), .out_sum(sum), .out_cout(cout),
        .busy(bsy)
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .clr(clr), .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_cin(cin1),
        .out_valid(ov1), .out_ready(ordy1), .out_sum(sum1), .out_cout(cout1),
        .busy(bsy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, sum} = a + b + cin modulo 2^9
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Issue one operation on the WIDTH=8 instance from IDLE and consume it.
    // lat counts rising edges from the accept edge (inclusive) up to the edge
    // after which out_valid is first seen.
    task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        int lat;
        logic [8:0] e;
        e = ref_add(x, y, c);
        a = x; b = y; cin = c; iv = 1'b1;
        tick();
        lat = 1;
        iv = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        while (!ov && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd9);
        chk({tag, "_sum"}, 64'(sum), 64'(e[7:0]));
        chk({tag, "_cout"}, 64'(cout), 64'(e[8]));
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk({tag, "_consumed"}, 64'(ov), 64'd0);
    endtask

    initial begin
        logic [8:0]  e;
        logic [8:0]  q[$];
        int          cyc, last_acc, issued, got, guard, lat, seen;
        logic        pend;
        logic [7:0]  rx, ry;
        logic        rc;

        clr = 1'b0; iv = 0; a = 0; b = 0; cin = 0; ordy = 0;
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; ordy1 = 0;
        tick(); tick();
        chk("rst_in_ready", 64'(ir), 64'd0);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_busy", 64'(bsy), 64'd0);
        chk("rst_sum", 64'({cout, sum}), 64'd0);
        clr = 1'b1;
        tick();
        chk("idle_in_ready", 64'(ir), 64'd1);
        chk("idle_busy", 64'(bsy), 64'd0);

        // Basic additions and carry boundaries
        op8("add_03_05", 8'h03, 8'h05, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0);
        op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        op8("add_00_00", 8'h00, 8'h00, 1'b0);

        // Back-pressure: result 0x30 held while out_ready low
        a = 8'h10; b = 8'h20; cin = 0; iv = 1'b1;
        tick();
        iv = 1'b0;
        lat = 1;
        while (!ov && lat < 40) begin tick(); lat++; end
        chk("bp_lat", 64'(lat), 64'd9);
        a = 8'h11; b = 8'h22; cin = 0; iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 64'(ir), 64'd0);
            chk("bp_hold", 64'({ov, cout, sum}), 64'h230);
        end
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("bp_release_idle", 64'({ov, ir}), 64'b01);
        tick();
        iv = 1'b0;
        chk("bp_next_busy", 64'(bsy), 64'd1);
        lat = 1;
        while (!ov && lat < 40) begin tick(); lat++; end
        e = ref_add(8'h11, 8'h22, 1'b0);
        chk("bp_next_lat", 64'(lat), 64'd9);
        chk("bp_next_res", 64'({cout, sum}), 64'(e));
        ordy = 1'b1; tick(); ordy = 1'b0;

        // Reset mid-operation: clr low at the edge where cnt==3
        a = 8'hA5; b = 8'h5A; cin = 1; iv = 1'b1;
        tick();                       // accept edge, cnt=0
        iv = 1'b0;
        tick(); tick(); tick();       // cnt now 3
        clr = 1'b0;
        tick();
        chk("abort_busy", 64'(bsy), 64'd0);
        chk("abort_ov", 64'(ov), 64'd0);
        clr = 1'b1;
        #1;
        chk("abort_idle", 64'({ir, bsy}), 64'b10);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        op8("post_abort", 8'h10, 8'h20, 1'b0);

        // Randomised stream with out_ready held high
        ordy = 1'b1;
        cyc = 0; last_acc = -1; issued = 0; got = 0; guard = 0; pend = 1'b0;
        while (got < 200 && guard < 5000) begin
            tick();
            cyc++; guard++;
            if (pend) begin
                if (last_acc >= 0) chk("rand_interval", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
                pend = 1'b0;
                iv = 1'b0;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            if (ov) begin
                if (q.size() == 0) chk("rand_spurious", 64'd1, 64'd0);
                else chk("rand_result", 64'({cout, sum}), 64'(q.pop_front()));
                got++;
            end
            if (ir && issued < 200) begin
                rx = 8'($urandom); ry = 8'($urandom); rc = 1'($urandom);
                a = rx; b = ry; cin = rc; iv = 1'b1;
                q.push_back(ref_add(rx, ry, rc));
                pend = 1'b1;
                issued++;
            end
        end
        chk("rand_count", 64'(got), 64'd200);
        ordy = 1'b0;
        iv = 1'b0;

        // WIDTH=1 instance: 1+1+1 = {1,1}
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1'b1;
        tick();
        iv1 = 1'b0; a1 = 0; b1 = 0; cin1 = 0;
        lat = 1;
        while (!ov1 && lat < 10) begin tick(); lat++; end
        chk("w1_lat", 64'(lat), 64'd2);
        chk("w1_res", 64'({cout1, sum1}), 64'b11);
        ordy1 = 1'b1; tick(); ordy1 = 1'b0;
        chk("w1_idle", 64'({ov1, ir1}), 64'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Sequencer and bit-serial datapath for multi-bit addition. Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake, feeds them LSB-first through a one-bit full-adder/carry-flop slice, and reassembles the sum and carry-out. The result is presented on a second valid/ready handshake. This is the block that sequences the serial adder for parallel producers and consumers.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-low reset
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  sum bits
- out_cout  out  1  carry-out
- busy  out  1  high in SHIFT or DONE

## Operation
- FSM states:
  - IDLE = 2'b00
  - SHIFT = 2'b01
  - DONE = 2'b10
  - 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: a_sr <= in_a, b_sr <= in_b, carry <= in_cin, cnt <= 0, sum_sr <= 0, go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right, zero-filled.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1, go to DONE.
- DONE:
  - out_valid = 1, out_sum = sum_sr, out_cout = carry.
  - All three are held stable until out_ready is sampled high, then go to IDLE.
- in_ready is 0 in SHIFT and DONE. No operand is accepted while a result is pending.
- out_sum and out_cout are driven 0 outside DONE.
- Arithmetic:
  - {out_cout, out_sum} = in_a + in_b + in_cin, computed modulo 2^(WIDTH+1).
  - No overflow flag.
- cnt is max($clog2(WIDTH),1) bits wide and never wraps past WIDTH-1.
- Reset, synchronous, clr low at an edge:
  - state = IDLE; a_sr, b_sr, sum_sr, carry and cnt = 0.
  - Reset overrides any handshake sampled on the same edge.
  - An operation in flight is discarded and no out_valid is produced for it.
- While clr is low:
  - in_ready = 0, out_valid = 0, busy = 0, out_sum = 0, out_cout = 0.
- Operand inputs are ignored except on the accepting edge.

## Timing
- Accept edge t: in_valid & in_ready sampled high.
- out_valid is first high in the cycle after edge t+WIDTH. Latency is WIDTH+1 cycles from the accept edge.
- With out_ready held high, DONE lasts 1 cycle and IDLE 1 cycle. Minimum issue interval is WIDTH+2 cycles.
- All outputs are functions of registered state only. There is no combinational path from in_valid or out_ready to any output.
- Back-pressure: DONE persists indefinitely while out_ready = 0.

## Structure
- Shared package serial_pkg:
  - FSM state encodings (ST_IDLE, ST_SHIFT, ST_DONE).
  - Default WIDTH constant SA_WIDTH_DEF = 8.
- Sub-module serial_add_slice:
  - Ports: clk, clr, en, a, b, cin_load, load, s, c.
  - Contents: full adder plus carry flop.
  - load forces carry <= cin_load.
  - en advances carry.
  - clr clears carry.
- The top level holds the FSM, counter and three shift registers.

## Test plan
- WIDTH=8, a=0x03, b=0x05, cin=0 -> out_sum=0x08, out_cout=0. out_valid first high exactly 9 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 -> out_sum=0x00, out_cout=1. Then a=0xFF, b=0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
- Back-pressure:
  - Stimulus: result 0x30 pending with out_ready low for 5 cycles; in_valid held high with a=0x11, b=0x22.
  - Required: in_ready=0 and out_sum stays 0x30 throughout.
  - Required: on the out_ready edge, go to IDLE; a=0x11, b=0x22 accepted on the following edge; result 0x33.
- Reset mid-operation:
  - Stimulus: clr low at the edge where cnt==3 in SHIFT.
  - Required: next cycle IDLE, busy=0, no out_valid for the aborted operation.
  - Required: after clr high, a=0x10, b=0x20, cin=0 -> 0x30, cout=0.
- Randomised-operand directed loop: 200 pairs with out_ready=1. Every result equals a+b+cin. Issue interval is exactly 10 cycles.
- WIDTH=1, a=1, b=1, cin=1 -> out_sum=1, out_cout=1. out_valid 2 cycles after accept.
